// File: rtl/uart_tx_buf.sv
// Buffered UART transmitter: 2^DEPTH_LOG2-byte FIFO feeding an 8N1 serial shifter.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx_buf #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BPS_UART   = 115200,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en,
    input  logic [7:0]          wr_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] level,
    output logic                overflow,
    output logic                uart_busy,
    output logic                uart_txd
);

    localparam int CNT_UART = CLK_FREQ / BPS_UART;
    localparam int DEPTH    = 1 << DEPTH_LOG2;
    localparam int BAUD_W   = $clog2(CNT_UART + 1);

    // Handshake: a byte is accepted on any rising edge with wr_en=1 and full=0;
    // a write seen while full=1 is dropped and latches overflow.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP
`ifdef UART_TX_PARITY_EN
        , PARITY
`endif
    } state_t;

    state_t                  state;
    logic [BAUD_W-1:0]       baud_cnt;
    logic [2:0]              bit_cnt;
    logic [7:0]              shifter;
`ifdef UART_TX_PARITY_EN
    logic                    parity_bit;
`endif

    logic [7:0]              mem [DEPTH];
    logic [DEPTH_LOG2-1:0]   wr_ptr;
    logic [DEPTH_LOG2-1:0]   rd_ptr;
    logic [7:0]              head;
    logic                    wr_ok;
    logic                    pop;
    logic                    baud_end;

    assign full  = (level == (DEPTH_LOG2 + 1)'(DEPTH));
    assign empty = (level == '0);
    assign head  = mem[rd_ptr];

    // A pop loads the shifter: from IDLE, or at the end of a stop bit for gapless frames.
    always_comb begin
        baud_end = (baud_cnt == BAUD_W'(CNT_UART - 1));
        wr_ok    = wr_en && !full;
        pop      = !empty && ((state == IDLE) || (state == STOP && baud_end));
    end

    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_ok, pop})
                2'b10:   level <= level + (DEPTH_LOG2 + 1)'(1);
                2'b01:   level <= level - (DEPTH_LOG2 + 1)'(1);
                default: level <= level;
            endcase
        end
    end

    // Line outputs are registered from the current state, so the line trails the FSM by one clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shifter    <= '0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
            uart_txd   <= 1'b1;
            uart_busy  <= 1'b0;
        end else begin
            case (state)
                START:   uart_txd <= 1'b0;
                DATA:    uart_txd <= shifter[0];
`ifdef UART_TX_PARITY_EN
                PARITY:  uart_txd <= parity_bit;
`endif
                default: uart_txd <= 1'b1;
            endcase
            uart_busy <= (state != IDLE);

            if (state == IDLE || baud_end) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (pop) begin
                        shifter    <= head;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= ^head;
`endif
                        state      <= START;
                    end
                end
                START: begin
                    if (baud_end) begin
                        bit_cnt <= '0;
                        state   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_end) begin
                        shifter <= shifter >> 1;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            state   <= PARITY;
`else
                            state   <= STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_end) begin
                        state <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_end) begin
                        if (pop) begin
                            shifter    <= head;
`ifdef UART_TX_PARITY_EN
                            parity_bit <= ^head;
`endif
                            state      <= START;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
